// File: rtl/mul_share_arb.sv
// Round-robin front end for one shared WIDTH x WIDTH multiplier serving two
// valid/ready requesters; each product returns as a strobe to its source.
module mul_share_arb #(
   parameter int WIDTH = 8,
   parameter int LAT   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               a_valid,
   output logic               a_ready,
   input  logic [WIDTH-1:0]   a_x,
   input  logic [WIDTH-1:0]   a_y,
   input  logic               b_valid,
   output logic               b_ready,
   input  logic [WIDTH-1:0]   b_x,
   input  logic [WIDTH-1:0]   b_y,
   output logic               a_res_valid,
   output logic [2*WIDTH-1:0] a_res,
   output logic               b_res_valid,
   output logic [2*WIDTH-1:0] b_res,
   output logic               busy,
   output logic               last_b
);

   localparam int PW = 2 * WIDTH;

   logic             w_grant_a;
   logic             w_grant_b;
   logic             w_xfer;
   logic             w_tag_p0;
   logic [WIDTH-1:0] w_x_p0;
   logic [WIDTH-1:0] w_y_p0;
   logic [PW-1:0]    w_prod_p0;
   logic             w_vld_out;
   logic             w_tag_out;
   logic [PW-1:0]    w_prod_out;

   logic             r_last_b;
   logic             r_a_res_valid;
   logic             r_b_res_valid;
   logic [PW-1:0]    r_a_res;
   logic [PW-1:0]    r_b_res;

   // A wins a contended cycle only when B took the previous grant.
   always_comb begin
      w_grant_a = a_valid && (!b_valid || r_last_b);
      w_grant_b = b_valid && !w_grant_a;
   end

   assign w_xfer    = w_grant_a || w_grant_b;
   assign w_tag_p0  = w_grant_b;
   assign w_x_p0    = w_grant_b ? b_x : a_x;
   assign w_y_p0    = w_grant_b ? b_y : a_y;
   assign w_prod_p0 = PW'(w_x_p0) * PW'(w_y_p0);

   // stage 0 -> stage 1 .. LAT-1 (the output registers form the last stage)
   generate
      if (LAT == 1) begin : g_direct
         assign w_vld_out  = w_xfer;
         assign w_tag_out  = w_tag_p0;
         assign w_prod_out = w_prod_p0;
         assign busy       = 1'b0;
      end else begin : g_pipe
         logic          r_vld_p  [LAT-1];
         logic          r_tag_p  [LAT-1];
         logic [PW-1:0] r_prod_p [LAT-1];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < LAT-1; i++) r_vld_p[i] <= 1'b0;
            end else begin
               r_vld_p[0] <= w_xfer;
               for (int i = 1; i < LAT-1; i++) r_vld_p[i] <= r_vld_p[i-1];
            end
         end

         always_ff @(posedge clk) begin
            r_tag_p[0]  <= w_tag_p0;
            r_prod_p[0] <= w_prod_p0;
            for (int i = 1; i < LAT-1; i++) begin
               r_tag_p[i]  <= r_tag_p[i-1];
               r_prod_p[i] <= r_prod_p[i-1];
            end
         end

         always_comb begin
            busy = 1'b0;
            for (int i = 0; i < LAT-1; i++) busy = busy | r_vld_p[i];
         end

         assign w_vld_out  = r_vld_p[LAT-2];
         assign w_tag_out  = r_tag_p[LAT-2];
         assign w_prod_out = r_prod_p[LAT-2];
      end
   endgenerate

   // output stage: the idle requester's bus keeps its last product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_b      <= 1'b1;
         r_a_res_valid <= 1'b0;
         r_b_res_valid <= 1'b0;
         r_a_res       <= '0;
         r_b_res       <= '0;
      end else begin
         r_a_res_valid <= w_vld_out && !w_tag_out;
         r_b_res_valid <= w_vld_out &&  w_tag_out;
         if (w_vld_out && !w_tag_out) r_a_res <= w_prod_out;
         if (w_vld_out &&  w_tag_out) r_b_res <= w_prod_out;
         if (w_xfer)                  r_last_b <= w_grant_b;
      end
   end

   assign a_ready     = w_grant_a;
   assign b_ready     = w_grant_b;
   assign a_res_valid = r_a_res_valid;
   assign b_res_valid = r_b_res_valid;
   assign a_res       = r_a_res;
   assign b_res       = r_b_res;
   assign last_b      = r_last_b;

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: LAT=2 and LAT=1 instances share stimulus and are
// compared each cycle against a transfer-history model of the arbiter.
module tb_mul_share_arb;

   logic       clk;
   logic       rst_n;
   logic       a_valid, b_valid;
   logic [7:0] a_x, a_y, b_x, b_y;

   logic        u2_a_ready, u2_b_ready, u2_a_res_valid, u2_b_res_valid, u2_busy, u2_last_b;
   logic [15:0] u2_a_res, u2_b_res;
   logic        u1_a_ready, u1_b_ready, u1_a_res_valid, u1_b_res_valid, u1_busy, u1_last_b;
   logic [15:0] u1_a_res, u1_b_res;

   mul_share_arb #(.WIDTH(8), .LAT(2)) u_lat2 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(u2_a_ready), .a_x(a_x), .a_y(a_y),
      .b_valid(b_valid), .b_ready(u2_b_ready), .b_x(b_x), .b_y(b_y),
      .a_res_valid(u2_a_res_valid), .a_res(u2_a_res),
      .b_res_valid(u2_b_res_valid), .b_res(u2_b_res),
      .busy(u2_busy), .last_b(u2_last_b)
   );

   mul_share_arb #(.WIDTH(8), .LAT(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(u1_a_ready), .a_x(a_x), .a_y(a_y),
      .b_valid(b_valid), .b_ready(u1_b_ready), .b_x(b_x), .b_y(b_y),
      .a_res_valid(u1_a_res_valid), .a_res(u1_a_res),
      .b_res_valid(u1_b_res_valid), .b_res(u1_b_res),
      .busy(u1_busy), .last_b(u1_last_b)
   );

   logic [37:0] obs2, obs1;
   assign obs2 = {u2_a_ready, u2_b_ready, u2_a_res_valid, u2_b_res_valid, u2_busy, u2_last_b, u2_a_res, u2_b_res};
   assign obs1 = {u1_a_ready, u1_b_ready, u1_a_res_valid, u1_b_res_valid, u1_busy, u1_last_b, u1_a_res, u1_b_res};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: every accepted transfer is logged by cycle; a result is
   // due exactly LAT cycles later unless a reset occurred at or after it.
   int          cyc      = 0;
   int          last_rst = -1;
   int          t;
   int          p;
   bit          hv    [4096];
   bit          hsrc  [4096];
   logic [15:0] hprod [4096];
   logic        m_last_b = 1'b1;
   logic        ga, gb, sa2, sb2, sa1, sb1, bz;
   logic [15:0] ra2 = '0, rb2 = '0, ra1 = '0, rb1 = '0;
   logic [37:0] exp2, exp1;

   always @(negedge clk) begin
      if (!rst_n) begin
         last_rst = cyc;
         m_last_b = 1'b1;
         ra2 = '0; rb2 = '0; ra1 = '0; rb1 = '0;
      end
      ga = a_valid && (!b_valid || m_last_b);
      gb = b_valid && !ga;
      sa2 = 0; sb2 = 0; sa1 = 0; sb1 = 0; bz = 0;
      if (rst_n) begin
         t = cyc - 2;
         if (t >= 0 && t > last_rst && hv[t]) begin
            if (hsrc[t]) begin sb2 = 1; rb2 = hprod[t]; end
            else         begin sa2 = 1; ra2 = hprod[t]; end
         end
         t = cyc - 1;
         if (t >= 0 && t > last_rst && hv[t]) begin
            bz = 1;
            if (hsrc[t]) begin sb1 = 1; rb1 = hprod[t]; end
            else         begin sa1 = 1; ra1 = hprod[t]; end
         end
      end
      exp2 = {ga, gb, sa2, sb2, bz,   m_last_b, ra2, rb2};
      exp1 = {ga, gb, sa1, sb1, 1'b0, m_last_b, ra1, rb1};
      if (rst_n && (ga || gb)) begin
         p           = gb ? int'(b_x) * int'(b_y) : int'(a_x) * int'(a_y);
         hv[cyc]     = 1'b1;
         hsrc[cyc]   = gb;
         hprod[cyc]  = p[15:0];
         m_last_b    = gb;
      end
      cyc++;
   end

   task automatic test_reset();
      rst_n = 1'b0; a_valid = 0; b_valid = 0; a_x = 0; a_y = 0; b_x = 0; b_y = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         n_checks += 3;
         if (obs2 !== exp2) begin n_fail++; $display("FAIL reset lat2 i=%0d got=%h exp=%h", i, obs2, exp2); end
         if (obs1 !== exp1) begin n_fail++; $display("FAIL reset lat1 i=%0d got=%h exp=%h", i, obs1, exp1); end
         if ({u2_last_b, u2_busy, u2_a_res_valid, u2_b_res_valid, u2_a_res, u2_b_res} !== {4'b1000, 32'h0}) begin
            n_fail++; $display("FAIL reset_values got last_b=%b busy=%b a_res=%0d b_res=%0d exp last_b=1 rest 0",
                               u2_last_b, u2_busy, u2_a_res, u2_b_res);
         end
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_a();
      for (int i = 0; i < 5; i++) begin
         a_valid = (i == 0); a_x = 8'd12; a_y = 8'd10; b_valid = 0;
         @(negedge clk); #1;
         n_checks += 3;
         if (obs2 !== exp2) begin n_fail++; $display("FAIL single_a lat2 i=%0d got=%h exp=%h", i, obs2, exp2); end
         if (obs1 !== exp1) begin n_fail++; $display("FAIL single_a lat1 i=%0d got=%h exp=%h", i, obs1, exp1); end
         if (u2_b_res_valid !== 1'b0) begin n_fail++; $display("FAIL single_a_b_strobe i=%0d got=%b exp=0", i, u2_b_res_valid); end
         if (i == 0) begin
            n_checks++;
            if (u2_a_ready !== 1'b1) begin n_fail++; $display("FAIL single_a_ready got=%b exp=1", u2_a_ready); end
         end
         if (i == 1 || i == 2) begin
            n_checks += 2;
            if ({u1_a_res_valid, u1_a_res} !== {(i == 1), 16'd120}) begin
               n_fail++; $display("FAIL single_a_lat1_res i=%0d got=%b/%0d exp=%b/120", i, u1_a_res_valid, u1_a_res, (i == 1));
            end
            if ({u2_a_res_valid, u2_a_res} !== {(i == 2), (i == 2) ? 16'd120 : 16'd0}) begin
               n_fail++; $display("FAIL single_a_lat2_res i=%0d got=%b/%0d exp=%b", i, u2_a_res_valid, u2_a_res, (i == 2));
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_only_b();
      for (int i = 0; i < 5; i++) begin
         a_valid = 0; b_valid = (i < 3); b_x = 8'(i + 1); b_y = 8'd127;
         @(negedge clk); #1;
         n_checks += 2;
         if (obs2 !== exp2) begin n_fail++; $display("FAIL only_b lat2 i=%0d got=%h exp=%h", i, obs2, exp2); end
         if (obs1 !== exp1) begin n_fail++; $display("FAIL only_b lat1 i=%0d got=%h exp=%h", i, obs1, exp1); end
         if (i < 3) begin
            n_checks++;
            if (u2_b_ready !== 1'b1) begin n_fail++; $display("FAIL only_b_ready i=%0d got=%b exp=1", i, u2_b_ready); end
         end
         if (i >= 2) begin
            n_checks++;
            if ({u2_b_res_valid, u2_b_res} !== {1'b1, 16'(127 * (i - 1))}) begin
               n_fail++; $display("FAIL only_b_res i=%0d got=%b/%0d exp=1/%0d", i, u2_b_res_valid, u2_b_res, 127 * (i - 1));
            end
         end
         if (i == 4) begin
            n_checks++;
            if (u2_last_b !== 1'b1) begin n_fail++; $display("FAIL only_b_last_b got=%b exp=1", u2_last_b); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         a_valid = (i < 6); a_x = 8'd255; a_y = 8'd255;
         b_valid = (i < 6); b_x = 8'd3;   b_y = 8'd7;
         @(negedge clk); #1;
         n_checks += 2;
         if (obs2 !== exp2) begin n_fail++; $display("FAIL b2b lat2 i=%0d got=%h exp=%h", i, obs2, exp2); end
         if (obs1 !== exp1) begin n_fail++; $display("FAIL b2b lat1 i=%0d got=%h exp=%h", i, obs1, exp1); end
         if (i < 6) begin
            n_checks++;
            if ({u2_a_ready, u2_b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
               n_fail++; $display("FAIL b2b_grant i=%0d got=%b%b exp=%s", i, u2_a_ready, u2_b_ready, (i % 2 == 0) ? "A" : "B");
            end
         end
         if (i >= 2) begin
            n_checks++;
            if (i % 2 == 0 && {u2_a_res_valid, u2_b_res_valid, u2_a_res} !== {2'b10, 16'd65025}) begin
               n_fail++; $display("FAIL b2b_a_res i=%0d got=%b%b/%0d exp=10/65025", i, u2_a_res_valid, u2_b_res_valid, u2_a_res);
            end
            if (i % 2 == 1 && {u2_a_res_valid, u2_b_res_valid, u2_b_res} !== {2'b01, 16'd21}) begin
               n_fail++; $display("FAIL b2b_b_res i=%0d got=%b%b/%0d exp=01/21", i, u2_a_res_valid, u2_b_res_valid, u2_b_res);
            end
         end
         if (i == 6) begin
            n_checks++;
            if (u2_last_b !== 1'b1) begin n_fail++; $display("FAIL b2b_last_b got=%b exp=1", u2_last_b); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 6; i++) begin
         a_valid = (i == 0); a_x = 8'd5; a_y = 8'd6;
         b_valid = (i < 2);  b_x = 8'd9; b_y = 8'd9;
         @(negedge clk); #1;
         n_checks += 2;
         if (obs2 !== exp2) begin n_fail++; $display("FAIL stall lat2 i=%0d got=%h exp=%h", i, obs2, exp2); end
         if (obs1 !== exp1) begin n_fail++; $display("FAIL stall lat1 i=%0d got=%h exp=%h", i, obs1, exp1); end
         if (i < 2) begin
            n_checks++;
            if ({u2_a_ready, u2_b_ready} !== ((i == 0) ? 2'b10 : 2'b01)) begin
               n_fail++; $display("FAIL stall_grant i=%0d got=%b%b exp=%s", i, u2_a_ready, u2_b_ready, (i == 0) ? "10" : "01");
            end
         end
         if (i == 3) begin
            n_checks++;
            if ({u2_b_res_valid, u2_b_res} !== {1'b1, 16'd81}) begin
               n_fail++; $display("FAIL stall_b_res got=%b/%0d exp=1/81", u2_b_res_valid, u2_b_res);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 6; i++) begin
         a_valid = (i < 2); a_x = 8'(i + 2); a_y = 8'd3; b_valid = 0;
         rst_n = (i != 2);
         @(negedge clk); #1;
         n_checks += 3;
         if (obs2 !== exp2) begin n_fail++; $display("FAIL reset_mid lat2 i=%0d got=%h exp=%h", i, obs2, exp2); end
         if (obs1 !== exp1) begin n_fail++; $display("FAIL reset_mid lat1 i=%0d got=%h exp=%h", i, obs1, exp1); end
         if (i >= 2 && {u2_a_res_valid, u2_b_res_valid, u2_busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_strobe i=%0d got=%b%b busy=%b exp=000", i, u2_a_res_valid, u2_b_res_valid, u2_busy);
         end
         if (i == 2) begin
            n_checks++;
            if ({u2_last_b, u2_a_res, u1_a_res_valid} !== {1'b1, 16'd0, 1'b0}) begin
               n_fail++; $display("FAIL reset_mid_values got last_b=%b a_res=%0d lat1_strobe=%b exp 1/0/0",
                                  u2_last_b, u2_a_res, u1_a_res_valid);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      bit a_hold = 0, b_hold = 0;
      for (int i = 0; i < 300; i++) begin
         if (!a_hold || $urandom_range(0, 9) == 0) begin
            a_valid = ($urandom_range(0, 9) < 6); a_x = 8'($urandom); a_y = 8'($urandom);
         end
         if (!b_hold || $urandom_range(0, 9) == 0) begin
            b_valid = ($urandom_range(0, 9) < 6); b_x = 8'($urandom); b_y = 8'($urandom);
         end
         @(negedge clk); #1;
         n_checks += 2;
         if (obs2 !== exp2) begin n_fail++; $display("FAIL random lat2 i=%0d got=%h exp=%h", i, obs2, exp2); end
         if (obs1 !== exp1) begin n_fail++; $display("FAIL random lat1 i=%0d got=%h exp=%h", i, obs1, exp1); end
         a_hold = a_valid && !u2_a_ready;
         b_hold = b_valid && !u2_b_ready;
         @(posedge clk); #1;
      end
      a_valid = 0; b_valid = 0;
   endtask

   task automatic test_zero_operand();
      for (int i = 0; i < 5; i++) begin
         a_valid = (i == 2); a_x = 8'd0; a_y = 8'd200; b_valid = 0;
         @(negedge clk); #1;
         n_checks += 2;
         if (obs2 !== exp2) begin n_fail++; $display("FAIL zero lat2 i=%0d got=%h exp=%h", i, obs2, exp2); end
         if (obs1 !== exp1) begin n_fail++; $display("FAIL zero lat1 i=%0d got=%h exp=%h", i, obs1, exp1); end
         if (i == 3) begin
            n_checks++;
            if ({u1_a_res_valid, u1_a_res} !== {1'b1, 16'd0}) begin
               n_fail++; $display("FAIL zero_lat1_res got=%b/%0d exp=1/0", u1_a_res_valid, u1_a_res);
            end
         end
         if (i == 4) begin
            n_checks++;
            if ({u2_a_res_valid, u2_a_res} !== {1'b1, 16'd0}) begin
               n_fail++; $display("FAIL zero_lat2_res got=%b/%0d exp=1/0", u2_a_res_valid, u2_a_res);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_single_a();
      test_only_b();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_random();
      test_zero_operand();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Round-robin arbiter and sequencer for a single shared unsigned WIDTH x WIDTH multiplier serving two requesters, A and B.
- Each requester offers an operand pair using a valid/ready handshake.
- The block grants at most one requester per cycle and pushes the pair into a LAT-stage multiplier pipeline, tagged with its source.
- It returns each product to the originating requester as a one-cycle result strobe.
- It sits in front of the shared-multiplier datapath (the sel_x-style x/y operand sharing) and replaces the free-running select toggle with demand-driven scheduling.

Parameters:
- WIDTH, 8, operand width; products are 2*WIDTH bits.
- LAT, 2, multiplier pipeline depth in cycles; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  requester A offers an operand pair.
- a_ready  output  1  A's pair is accepted this cycle.
- a_x  input  WIDTH  A operand x.
- a_y  input  WIDTH  A operand y.
- b_valid  input  1  requester B offers an operand pair.
- b_ready  output  1  B's pair is accepted this cycle.
- b_x  input  WIDTH  B operand x.
- b_y  input  WIDTH  B operand y.
- a_res_valid  output  1  one-cycle strobe: a_res holds A's product.
- a_res  output  2*WIDTH  A product.
- b_res_valid  output  1  one-cycle strobe: b_res holds B's product.
- b_res  output  2*WIDTH  B product.
- busy  output  1  at least one product is in flight in the pipeline.
- last_b  output  1  the most recent grant went to B.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - a_res_valid=0, b_res_valid=0, a_res=0, b_res=0.
  - All pipeline valid bits cleared, busy=0.
  - last_b=1, so A wins the first contended cycle.
- Arbitration (combinational from the valids and last_b):
  - Only a_valid high: a_ready=1.
  - Only b_valid high: b_ready=1.
  - Both high: grant to A if last_b=1, otherwise to B.
  - Neither high: both ready=0.
  - a_ready and b_ready are never high together.
  - A ready is never asserted without its own valid.
- Handshake:
  - A transfer occurs in any cycle where valid && ready.
  - A requester holding valid while ready=0 must keep x/y stable; the block does not check this.
  - A requester may drop valid at any time without penalty.
- Grant state: last_b updates only on a transfer (1 for B, 0 for A). Idle cycles leave it unchanged.
- Pipeline:
  - A transfer in cycle n launches {tag, x*y} into stage 1.
  - The result strobe for that transfer is high in cycle n+LAT only, with the product registered on the outputs.
  - Throughput is one transfer per cycle. There is no result backpressure; requesters must always sink results.
- Results:
  - The tag selects which strobe fires.
  - The non-selected res bus holds its previous value.
  - Exactly one strobe fires per transfer. Results leave in acceptance order.
- Arithmetic: unsigned full-width product, no truncation. 255*255=65025 for WIDTH=8.
- busy is the OR of all pipeline stage valid bits. It does not include the output strobe cycle.
- Back-to-back: alternating grants under continuous contention give strict A,B,A,B ordering with no bubbles.
- Reset asserted mid-operation: in-flight products are discarded, no strobe fires for them, and outputs return to reset values immediately.
- After rst_n deasserts, the first transfer may occur in the first cycle with a valid high.

Test Plan:
- Reset then a single A request, a_x=12, a_y=10, LAT=2 -> a_ready=1 in cycle 0, a_res_valid=1 with a_res=120 in cycle 2 only, b_res_valid stays 0.
- a_valid and b_valid held high for 6 cycles, A=(255,255), B=(3,7) -> grants A,B,A,B,A,B; strobes alternate starting cycle 2: a_res=65025, b_res=21; last_b=1 at the end.
- Only B valid for 3 cycles with b_x=1,2,3 and b_y=127 -> b_ready=1 every cycle; b_res=127,254,381 in consecutive cycles; last_b=1.
- A contended pair stalls B, with a_valid and b_valid=1 and last_b=1 -> A granted; B's operands (9,9) held; B granted next cycle; b_res=81 at cycle 1+LAT.
- rst_n pulsed low one cycle after two transfers -> no res strobes ever fire for them, busy=0 immediately, last_b=1.
- LAT=1 rerun of scenario 1 -> a_res=120 in cycle 1; zero operands (0,200) -> a_res=0 with strobe still high.
